// File: rtl/load_store_unit.sv
// RV32 load/store unit: one request at a time, aligned word bus transactions,
// lane select and sign/zero extension on loads, bus timeout and alignment faults.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic        fault_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, WB, ERR} state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        ft_q, ft_d;

  function automatic logic is_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  // Width is encoded in funct3[1:0] for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0]        lane;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    lane = rdata >> {off, 3'b000};
    b_s  = lane[7:0];
    h_s  = lane[15:0];
    case (f3)
      3'b000:  begin ext = b_s; return ext; end
      3'b001:  begin ext = h_s; return ext; end
      3'b100:  return {24'h0, lane[7:0]};
      3'b101:  return {16'h0, lane[15:0]};
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    rd_d        = rd_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    ft_d        = ft_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d      = req_addr[1:0];
          funct3_d   = req_funct3;
          is_store_d = req_is_store;
          rd_d       = req_rd;
          if (!is_legal(req_is_store, req_funct3) ||
              is_misaligned(req_funct3, req_addr[1:0])) begin
            state_d = ERR;
            ft_d    = 1'b0;
          end else begin
            state_d    = BUS;
            cnt_d      = '0;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_is_store) begin
              mem_be_d    = store_be(req_funct3, req_addr[1:0]);
              mem_wdata_d = store_lanes(req_funct3, req_wdata);
            end else begin
              mem_be_d = 4'b1111;
            end
          end
        end
      end
      BUS: begin
        // An ack in the final counted cycle still completes the access.
        if (mem_ack) begin
          cnt_d = '0;
          if (is_store_q) begin
            state_d = IDLE;
          end else begin
            state_d   = WB;
            wb_rd_d   = rd_q;
            wb_data_d = load_extract(funct3_q, off_q, mem_rdata);
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ERR;
          ft_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB:      state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      is_store_q  <= 1'b0;
      rd_q        <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      ft_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      rd_q        <= rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      ft_q        <= ft_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign mem_req       = (state_q == BUS);
  assign mem_we        = mem_req & is_store_q;
  assign mem_addr      = mem_addr_q;
  assign mem_be        = mem_be_q;
  assign mem_wdata     = mem_wdata_q;
  assign wb_valid      = (state_q == WB);
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign fault         = (state_q == ERR);
  assign fault_timeout = ft_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level timeline model, per-cycle compare,
// directed corner cases with literal expectations, then randomized operations.
module tb_load_store_unit;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic        wb_valid, fault, fault_timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .fault(fault), .fault_timeout(fault_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic bit model_legal(input bit st, input logic [2:0] f3);
    if (st) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic bit model_misal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd1 || f3 == 3'd5) return a % 2 != 0;
    if (f3 == 3'd2) return a % 4 != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int o;
    o = int'(a % 4);
    if (!st) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << o);
    if (f3 == 3'd1) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (f3 == 3'd1) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [7:0]  by [4];
    logic [15:0] h;
    int o;
    for (int i = 0; i < 4; i++) by[i] = rd[8*i +: 8];
    o = int'(a % 4);
    h = {by[(o + 1) % 4], by[o]};
    case (f3)
      3'd0:    return {{24{by[o][7]}}, by[o]};
      3'd4:    return {24'h0, by[o]};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  // current transaction, written only by the driver
  bit          act = 1'b0, chk_en = 1'b0;
  int          acc = 0, t_k = 0;
  bit          t_st = 1'b0;
  logic [2:0]  t_f3 = '0;
  logic [31:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
  logic [4:0]  t_rd = '0;

  int cyc = 0;
  logic rst_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // ---------------- compare process ----------------
  logic [31:0] exp_wb_data = '0;
  logic [4:0]  exp_wb_rd = '0;
  logic        exp_ft = 1'b0;
  int r, bus_end, wb_r, fault_r, end_r;
  bit e_ready, e_req, e_wbv, e_fault, e_ft;
  int obs_req_n, obs_wbv_n, obs_fault_n, obs_wb_r, obs_fault_r;
  logic        obs_we, obs_ft;
  logic [31:0] obs_addr, obs_wdata, obs_wb_data;
  logic [3:0]  obs_be;

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst_at_edge) begin
        exp_wb_data = '0; exp_wb_rd = '0; exp_ft = 1'b0;
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
      end
      e_ready = 1'b1; e_req = 1'b0; e_wbv = 1'b0; e_fault = 1'b0;
      r = -1;
      if (act) begin
        r = cyc - acc;
        wb_r = -1; fault_r = -1; e_ft = 1'b0;
        if (!model_legal(t_st, t_f3) || model_misal(t_f3, t_addr)) begin
          bus_end = 0; fault_r = 1; end_r = 2;
        end else if (t_k >= 1 && t_k <= T) begin
          bus_end = t_k;
          if (t_st) end_r = t_k + 1;
          else begin wb_r = t_k + 1; end_r = t_k + 2; end
        end else begin
          bus_end = T; fault_r = T + 1; e_ft = 1'b1; end_r = T + 2;
        end
        e_ready = (r == 0) || (r >= end_r);
        e_req   = (r >= 1) && (r <= bus_end);
        e_wbv   = (r == wb_r);
        e_fault = (r == fault_r);
        if (e_wbv) begin exp_wb_data = model_load(t_f3, t_addr, t_rdata); exp_wb_rd = t_rd; end
        if (e_fault) exp_ft = e_ft;
        if (e_req) begin
          check("mem_we", 32'(mem_we), 32'(t_st));
          check("mem_addr", mem_addr, {t_addr[31:2], 2'b00});
          check("mem_be", 32'(mem_be), 32'(model_be(t_st, t_f3, t_addr)));
          if (t_st) check("mem_wdata", mem_wdata, model_wdata(t_f3, t_wdata));
        end
        if (r == 0) begin
          obs_req_n = 0; obs_wbv_n = 0; obs_fault_n = 0; obs_wb_r = -1; obs_fault_r = -1;
        end
      end
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("mem_req", 32'(mem_req), 32'(e_req));
      check("wb_valid", 32'(wb_valid), 32'(e_wbv));
      check("fault", 32'(fault), 32'(e_fault));
      check("wb_data", wb_data, exp_wb_data);
      check("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
      check("fault_timeout", 32'(fault_timeout), 32'(exp_ft));
      if (mem_req) begin
        if (obs_req_n == 0) begin
          obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
        end
        obs_req_n++;
      end
      if (wb_valid) begin obs_wbv_n++; obs_wb_r = r; obs_wb_data = wb_data; end
      if (fault) begin obs_fault_n++; obs_fault_r = r; obs_ft = fault_timeout; end
    end
  end

  // ---------------- driver ----------------
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int k, input int rst_at);
    @(posedge clk); #1;
    t_st = st; t_f3 = f3; t_addr = a; t_wdata = wd; t_rd = rd; t_rdata = rdata; t_k = k;
    acc = cyc; act = 1'b1;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a;
    req_wdata = wd; req_rd = rd; mem_ack = 1'b0;
    for (int i = 1; i <= T + 3; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      rst = (i == rst_at);
      if (rst_at > 0 && i == rst_at + 1) act = 1'b0;
      if (i == k) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end else begin
        mem_ack   = (i == T + 3) ? 1'($urandom % 2) : 1'b0;
        mem_rdata = $urandom;
      end
    end
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;

    check("pin_lbu", model_load(3'd4, 32'h103, 32'hFF123456), 32'h000000FF);
    check("pin_lhu", model_load(3'd5, 32'h102, 32'hFF123456), 32'h0000FF12);
    check("pin_sh_be", 32'(model_be(1'b1, 3'd1, 32'h202)), 32'hC);

    run_op(1'b0, 3'd4, 32'h103, 32'h0, 5'd7, 32'hFF123456, 1, 0);
    check("lbu_data", obs_wb_data, 32'h000000FF);
    check("lbu_addr", obs_addr, 32'h100);
    check("lbu_lat", 32'(obs_wb_r), 32'd2);
    run_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd8, 32'hFF123456, 1, 0);
    check("lb_data", obs_wb_data, 32'hFFFFFFFF);
    run_op(1'b0, 3'd5, 32'h102, 32'h0, 5'd9, 32'hFF123456, 1, 0);
    check("lhu_data", obs_wb_data, 32'h0000FF12);
    run_op(1'b0, 3'd2, 32'h100, 32'h0, 5'd10, 32'h00000000, 1, 0);
    check("lw_data", obs_wb_data, 32'h0);
    run_op(1'b1, 3'd1, 32'h202, 32'h0000ABCD, 5'd0, 32'h0, 1, 0);
    check("sh_we", 32'(obs_we), 32'd1);
    check("sh_addr", obs_addr, 32'h200);
    check("sh_be", 32'(obs_be), 32'hC);
    check("sh_wdata", obs_wdata, 32'hABCDABCD);
    check("sh_no_wb", 32'(obs_wbv_n), 32'd0);
    run_op(1'b0, 3'd2, 32'h101, 32'h0, 5'd3, 32'h0, 1, 0);
    check("mis_fault_at", 32'(obs_fault_r), 32'd1);
    check("mis_ft", 32'(obs_ft), 32'd0);
    check("mis_no_req", 32'(obs_req_n), 32'd0);
    run_op(1'b0, 3'd3, 32'h100, 32'h0, 5'd3, 32'h0, 1, 0);
    check("ill_fault_at", 32'(obs_fault_r), 32'd1);
    check("ill_ft", 32'(obs_ft), 32'd0);
    check("ill_no_req", 32'(obs_req_n), 32'd0);
    run_op(1'b0, 3'd2, 32'h400, 32'h0, 5'd4, 32'h12345678, 0, 0);
    check("to_req_cycles", 32'(obs_req_n), 32'd4);
    check("to_fault_at", 32'(obs_fault_r), 32'd5);
    check("to_ft", 32'(obs_ft), 32'd1);
    run_op(1'b0, 3'd2, 32'h400, 32'h0, 5'd5, 32'h12345678, 4, 0);
    check("ack4_no_fault", 32'(obs_fault_n), 32'd0);
    check("ack4_wb_at", 32'(obs_wb_r), 32'd5);
    check("ack4_data", obs_wb_data, 32'h12345678);
    run_op(1'b0, 3'd2, 32'h500, 32'h0, 5'd6, 32'hCAFEF00D, 4, 2);
    check("rst_no_wb", 32'(obs_wbv_n), 32'd0);
    check("rst_no_fault", 32'(obs_fault_n), 32'd0);

    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom % 2);
      f3 = ($urandom % 4 == 0) ? 3'($urandom) : (st ? 3'($urandom % 3) : 3'($urandom % 3 + (($urandom % 2) ? 3'd4 : 3'd0)));
      run_op(st, f3, $urandom, $urandom, 5'($urandom), $urandom,
             int'($urandom % (T + 2)), 0);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the number of BUS-state cycles without mem_ack before the unit aborts with a timeout fault.
- REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
- REQ-004 SHALL have port req_valid, input, 1 bit: the execute stage presents a memory operation.
- REQ-005 SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
- REQ-006 SHALL have port req_is_store, input, 1 bit: 1 = store, 0 = load.
- REQ-007 SHALL have port req_funct3, input, 3 bits: RISC-V width/sign code.
- REQ-008 SHALL have port req_addr, input, 32 bits: the byte address.
- REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
- REQ-010 SHALL have port req_rd, input, 5 bits: the load destination register.
- REQ-011 SHALL have the following memory-bus ports:
  - mem_req, output, 1 bit: bus request.
  - mem_we, output, 1 bit: write enable.
  - mem_addr, output, 32 bits: word address, with bits [1:0] = 00.
  - mem_be, output, 4 bits: byte enables.
  - mem_wdata, output, 32 bits: lane-aligned write data.
- REQ-012 SHALL have port mem_ack, input, 1 bit, and port mem_rdata, input, 32 bits: the bus response.
- REQ-013 SHALL have the following writeback ports toward the register file:
  - wb_valid, output, 1 bit.
  - wb_rd, output, 5 bits.
  - wb_data, output, 32 bits.
- REQ-014 SHALL have port fault, output, 1 bit, and port fault_timeout, output, 1 bit: fault = 1-cycle error pulse; fault_timeout = 1 if the cause is timeout, 0 if the cause is misalignment or an illegal funct3.

Function
- REQ-015 SHALL implement the states IDLE, BUS, WB and ERR.
- REQ-016 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a rising edge, and addr/funct3/wdata/rd/is_store are latched at that edge.
- REQ-017 SHALL, on accept, check the request:
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- REQ-018 SHALL treat a halfword with addr[0]=1 as misaligned, and a word with addr[1:0]≠00 as misaligned.
- REQ-019 SHALL, for an illegal or misaligned request, go IDLE→ERR with no mem_req; otherwise it SHALL go IDLE→BUS.
- REQ-020 SHALL, in BUS, hold mem_req=1 with mem_we, mem_addr, mem_be and mem_wdata stable until mem_ack=1 is sampled.
- REQ-021 SHALL make mem_req first visible in the cycle after accept.
- REQ-022 SHALL, for stores, set mem_be to the bytes selected by addr[1:0] and width:
  - SB: 0001 << addr[1:0].
  - SH: 0011 << addr[1:0].
  - SW: 1111.
  - mem_wdata = req_wdata replicated into the byte lanes (byte ×4, half ×2).
- REQ-023 SHALL, for loads, drive mem_we=0 and mem_be=1111.
- REQ-024 SHALL, when mem_ack arrives on a load, select the byte/half lane from mem_rdata using addr[1:0]:
  - LB/LH: sign-extend to 32 bits.
  - LBU/LHU: zero-extend to 32 bits.
  - LW: pass through.
  - The result is registered into wb_data, and the state goes BUS→WB.
- REQ-025 SHALL, when mem_ack arrives on a store, go BUS→IDLE, with no wb_valid.
- REQ-026 SHALL, in WB, assert wb_valid=1 for exactly one cycle, with wb_rd = the latched rd, then go WB→IDLE.
- REQ-027 SHALL, if mem_ack comes in BUS cycle k (k=1 is the first mem_req cycle), give load latency accept→wb_valid = k+1 cycles and store accept→req_ready = k+1 cycles.
- REQ-028 SHALL count BUS cycles; when the count reaches TIMEOUT_CYCLES without mem_ack, it SHALL drop mem_req and go BUS→ERR with fault_timeout=1.
- REQ-029 SHALL give mem_ack priority over timeout when both occur in the same cycle.
- REQ-030 SHALL, in ERR, assert fault=1 for one cycle, then go ERR→IDLE; no writeback occurs for a faulting request.
- REQ-031 SHALL ignore mem_ack outside BUS.
- REQ-032 SHALL leave wb_data, wb_rd and fault_timeout holding their last values outside their valid cycle.

Reset
- REQ-033 SHALL, while rst=1 at a rising edge, force:
  - State: IDLE; timeout counter: 0.
  - Control outputs: mem_req=0, mem_we=0, wb_valid=0, fault=0.
  - Data outputs: fault_timeout=0, mem_addr=0, mem_be=0, mem_wdata=0, wb_rd=0, wb_data=0.
- REQ-034 SHALL abort any operation when rst is asserted mid-operation: mem_req is 0 in the cycle after the reset edge, with no wb_valid and no fault.
- REQ-035 SHALL drive req_ready=1 in the first cycle after rst deasserts.

Verification
- REQ-036 SHALL cover LBU: addr 0x103, mem_rdata 0xFF123456, ack on the 1st BUS cycle → mem_addr 0x100, wb_data 0x000000FF, wb_valid exactly 2 cycles after accept.
- REQ-037 SHALL cover LB: same stimulus as REQ-036 → wb_data 0xFFFFFFFF. LHU addr 0x102 → 0x0000FF12. LW addr 0x100 with mem_rdata 0x00000000 → wb_data 0x0.
- REQ-038 SHALL cover SH: addr 0x202, wdata 0x0000ABCD → mem_we=1, mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD, no wb_valid.
- REQ-039 SHALL cover misalignment: LW addr 0x101, and separately funct3=011 load → fault=1 one cycle later, fault_timeout=0, mem_req never asserted.
- REQ-040 SHALL cover timeout: TIMEOUT_CYCLES=4, no ack → mem_req high for 4 cycles, then fault=1 with fault_timeout=1. A separate run with ack on cycle 4 → normal completion with no fault.
- REQ-041 SHALL cover reset mid-operation: rst pulsed on BUS cycle 2 → mem_req=0 next cycle, req_ready=1 after release, and no wb_valid from a later-arriving mem_ack.
